// File: rtl/ifid_buffer.sv
// ifid_buffer: two-entry FIFO between fetch and decode.
// Flush discards all stored pairs and the pair offered in the same cycle.
// in_ready and freeze are decoded from the occupancy state only.
// Optional feature macro: IFID_BUF_STATS_EN adds the saturating counters
// stall_cnt and flush_cnt.
module ifid_buffer #(
  parameter int WORD_LEN = 32,
  parameter int STAT_LEN = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  input  logic [WORD_LEN-1:0] in_pc,
  input  logic [WORD_LEN-1:0] in_instr,
  output logic                in_ready,
  output logic                freeze,
  input  logic                flush,
  output logic                out_valid,
  output logic [WORD_LEN-1:0] out_pc,
  output logic [WORD_LEN-1:0] out_instr,
  input  logic                out_ready
`ifdef IFID_BUF_STATS_EN
  ,
  output logic [STAT_LEN-1:0] stall_cnt,
  output logic [STAT_LEN-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  state_e                    state_q, state_d;
  logic                      rd_ptr_q, rd_ptr_d;
  logic                      wr_ptr_q, wr_ptr_d;
  logic [1:0][WORD_LEN-1:0]  pc_mem_q, pc_mem_d;
  logic [1:0][WORD_LEN-1:0]  instr_mem_q, instr_mem_d;
  logic                      push, pop;

  // Handshake decode; readiness depends on state only
  always_comb begin
    in_ready  = (state_q != FULL);
    freeze    = ~in_ready;
    out_valid = (state_q != EMPTY);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
    out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
    out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
  end

  // Next occupancy, pointers and storage; flush overrides everything
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (push) begin
      pc_mem_d[wr_ptr_q]    = in_pc;
      instr_mem_d[wr_ptr_q] = in_instr;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d  = EMPTY;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
  end

  // State register, cleared asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= EMPTY;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      pc_mem_q    <= '0;
      instr_mem_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

`ifdef IFID_BUF_STATS_EN
  logic [STAT_LEN-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_LEN-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (in_valid && !in_ready && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && !(&flush_cnt_q))                 flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic [STAT_LEN-1:0] stat_unused;
  assign stat_unused = '0;
`endif

endmodule

// File: doc/ifid_buffer.md
IFID_BUFFER -- requirements
Module: ifid_buffer

Interface
REQ-001 Parameter WORD_LEN, default 32, width of PC and instruction words.
REQ-002 Parameter STAT_LEN, default 16, width of statistics counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  fetch stage presents a valid PC/instruction pair.
REQ-006 in_pc  input  WORD_LEN  PC of the fetched instruction.
REQ-007 in_instr  input  WORD_LEN  fetched instruction word.
REQ-008 in_ready  output  1  buffer can accept a pair this cycle.
REQ-009 freeze  output  1  fetch-stage PC hold request; always equal to ~in_ready.
REQ-010 flush  input  1  branch taken; discard all buffered and incoming pairs.
REQ-011 out_valid  output  1  head entry valid toward decode.
REQ-012 out_pc  output  WORD_LEN  PC of head entry.
REQ-013 out_instr  output  WORD_LEN  instruction of head entry.
REQ-014 out_ready  input  1  decode stage consumes head entry this cycle.

Function
REQ-015 Block SHALL be a 2-entry FIFO with occupancy states EMPTY (0), ONE (1) and FULL (2).
REQ-016 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, decoded from state only, with no combinational path from any input.
REQ-017 Push SHALL occur when in_valid & in_ready & ~flush; pop SHALL occur when out_valid & out_ready & ~flush.
REQ-018 out_valid SHALL be 1 in ONE and FULL; out_pc/out_instr SHALL show the oldest entry and hold stable while out_valid & ~out_ready.
REQ-019 Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; FULL->ONE on pop; all other cases hold state.
REQ-020 Push and pop in the same cycle in ONE SHALL keep ONE, with the new pair at head on the next cycle.
REQ-021 Push in FULL is impossible (in_ready=0); a pop in FULL SHALL not accept input in that same cycle.
REQ-022 Latency: a pair pushed into EMPTY at edge N SHALL appear on out_* with out_valid=1 after edge N.
REQ-023 flush SHALL take priority over push and pop: the state SHALL go to EMPTY at the next edge, and the same-cycle input SHALL be dropped.
REQ-024 When out_valid=0, out_pc and out_instr SHALL be driven to 0.
REQ-025 Read and write pointers SHALL be 1 bit each and wrap modulo 2; order SHALL be strictly FIFO.

Reset
REQ-026 On rstn=0, the block SHALL clear immediately, regardless of clk: state EMPTY, pointers 0, out_valid=0, out_pc=0, out_instr=0, in_ready=1, freeze=0, and counters 0.
REQ-027 Reset asserted mid-operation SHALL discard all entries; after release, the first push SHALL behave as from EMPTY.

Configuration
REQ-028 With macro IFID_BUF_STATS_EN defined, the block SHALL add outputs stall_cnt[STAT_LEN] and flush_cnt[STAT_LEN].
REQ-029 stall_cnt SHALL increment on every cycle with in_valid & ~in_ready; flush_cnt SHALL increment on every cycle with flush=1; both SHALL saturate at all-ones.
REQ-030 Without IFID_BUF_STATS_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then push pc=0x0, instr=0x00000013 into EMPTY with out_ready=1 -> one cycle later out_valid=1, out_pc=0x0; the next cycle out_valid=0.
REQ-032 Hold out_ready=0, push pc=0x4 then 0x8 -> FULL, in_ready=0, freeze=1; out_pc stays 0x4; a third offered pc=0xC is not accepted.
REQ-033 From FULL, set out_ready=1 for 3 cycles with in_valid=1, pc=0xC -> outputs 0x4, 0x8, 0xC in order, with no loss or duplicate.
REQ-034 In ONE, assert flush with in_valid=1, pc=0x10 -> next cycle EMPTY, out_valid=0; 0x10 never appears at the output.
REQ-035 Assert rstn=0 between clock edges while FULL -> out_valid=0 and in_ready=1 before the next edge.
REQ-036 With IFID_BUF_STATS_EN: 5 cycles of stall in FULL plus 2 flush cycles -> stall_cnt=5, flush_cnt=2; with counters preset near all-ones, 0xFFFF plus further events stays 0xFFFF.
